// File: rtl/aidc_lite_comp_buf_ctrl.sv
// aidc_lite_comp_buf_ctrl: store-and-forward buffer controller for compressed 64-bit packets
module aidc_lite_comp_buf_ctrl #(
    parameter int ADDR_WIDTH = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush_i,
    input  logic                  s_valid_i,
    output logic                  s_ready_o,
    input  logic [63:0]           s_data_i,
    input  logic                  s_last_i,
    output logic                  buf_wren_o,
    output logic [ADDR_WIDTH-1:0] buf_waddr_o,
    output logic [63:0]           buf_wdata_o,
    output logic [ADDR_WIDTH-1:0] buf_raddr_o,
    input  logic [63:0]           buf_rdata_i,
    output logic                  m_valid_o,
    input  logic                  m_ready_i,
    output logic [63:0]           m_data_o,
    output logic                  m_last_o,
    output logic [ADDR_WIDTH:0]   occupancy_o,
    output logic [ADDR_WIDTH:0]   pkt_cnt_o
);
    localparam int DEPTH = 1 << ADDR_WIDTH;
    logic [ADDR_WIDTH:0] wr_ptr, rd_ptr, pkt_cnt, pkt_nxt;
    logic [DEPTH-1:0]    last_q;
    logic                empty, full, push, pop, inc, dec;
    assign empty       = wr_ptr == rd_ptr;
    assign full        = (wr_ptr ^ rd_ptr) == {1'b1, {ADDR_WIDTH{1'b0}}};
    assign s_ready_o   = !full && !flush_i;
    assign push        = s_valid_i && s_ready_o;
    assign buf_wren_o  = push;
    assign buf_waddr_o = wr_ptr[ADDR_WIDTH-1:0];
    assign buf_wdata_o = s_data_i;
    assign buf_raddr_o = rd_ptr[ADDR_WIDTH-1:0];
    // A full buffer forwards even without a complete packet so oversize packets cannot deadlock
    assign m_valid_o   = !empty && (pkt_cnt != '0 || full) && !flush_i;
    assign m_data_o    = buf_rdata_i;
    assign m_last_o    = last_q[rd_ptr[ADDR_WIDTH-1:0]] && m_valid_o;
    assign pop         = m_valid_o && m_ready_i;
    assign inc         = push && s_last_i;
    assign dec         = pop && m_last_o;
    assign occupancy_o = wr_ptr - rd_ptr;
    assign pkt_cnt_o   = pkt_cnt;
    // Packet count update, saturating at zero when a cut-through tail leaves with no packet counted
    always_comb begin
        pkt_nxt = (inc && !dec) ? pkt_cnt + 1'b1 :
                  (dec && !inc && pkt_cnt != '0) ? pkt_cnt - 1'b1 : pkt_cnt;
    end
    // Pointer, last-flag and packet-count state; reset beats flush beats push/pop
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            pkt_cnt <= '0;
            last_q  <= '0;
        end else if (flush_i) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            pkt_cnt <= '0;
        end else begin
            if (push) begin
                last_q[wr_ptr[ADDR_WIDTH-1:0]] <= s_last_i;
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            pkt_cnt <= pkt_nxt;
        end
    end
endmodule

// File: tb/tb_aidc_lite_comp_buf_ctrl.sv
// tb_aidc_lite_comp_buf_ctrl: table-driven and sequence checks of the buffer controller
module tb_aidc_lite_comp_buf_ctrl;
    logic        clk = 1'b0;
    logic        rst, flush_i, s_valid_i, s_ready_o, s_last_i;
    logic [63:0] s_data_i, buf_wdata_o, buf_rdata_i, m_data_o;
    logic        buf_wren_o, m_valid_o, m_ready_i, m_last_o;
    logic [2:0]  buf_waddr_o, buf_raddr_o;
    logic [3:0]  occupancy_o, pkt_cnt_o;
    logic [63:0] mem [8];
    int          n_cmp = 0, n_bad = 0;

    typedef struct {
        int rst, flush, sv; logic [63:0] sd; int sl, mr;
        int sr, wr, wa, ra, mv, ml; logic [63:0] md; int occ, pkt;
    } vec_t;
    vec_t vecs [29];

    aidc_lite_comp_buf_ctrl #(.ADDR_WIDTH(3)) dut (
        .clk(clk), .rst(rst), .flush_i(flush_i),
        .s_valid_i(s_valid_i), .s_ready_o(s_ready_o), .s_data_i(s_data_i), .s_last_i(s_last_i),
        .buf_wren_o(buf_wren_o), .buf_waddr_o(buf_waddr_o), .buf_wdata_o(buf_wdata_o),
        .buf_raddr_o(buf_raddr_o), .buf_rdata_i(buf_rdata_i),
        .m_valid_o(m_valid_o), .m_ready_i(m_ready_i), .m_data_o(m_data_o), .m_last_o(m_last_o),
        .occupancy_o(occupancy_o), .pkt_cnt_o(pkt_cnt_o)
    );

    always #5 clk = ~clk;

    // External buffer RAM with combinational read
    always @(posedge clk) if (buf_wren_o) mem[buf_waddr_o] <= buf_wdata_o;
    assign buf_rdata_i = mem[buf_raddr_o];

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic f, input logic sv, input logic [63:0] sd,
                         input logic sl, input logic mr);
        @(negedge clk);
        rst = r; flush_i = f; s_valid_i = sv; s_data_i = sd; s_last_i = sl; m_ready_i = mr;
        #1;
    endtask

    initial begin
        int sent, recv;
        //            rst fl sv  sd        sl mr  sr wr wa ra mv ml md        occ pkt
        vecs[0]  = '{0, 0, 0, 64'h0,   0, 0,  1, 0, 0, 0, 0, 0, 64'h0,   0, 0};
        vecs[1]  = '{0, 0, 1, 64'h11,  0, 1,  1, 1, 0, 0, 0, 0, 64'h0,   0, 0};
        vecs[2]  = '{0, 0, 1, 64'h12,  0, 1,  1, 1, 1, 0, 0, 0, 64'h0,   1, 0};
        vecs[3]  = '{0, 0, 1, 64'h13,  1, 1,  1, 1, 2, 0, 0, 0, 64'h0,   2, 0};
        vecs[4]  = '{0, 0, 0, 64'h0,   0, 1,  1, 0, 3, 0, 1, 0, 64'h11,  3, 1};
        vecs[5]  = '{0, 0, 0, 64'h0,   0, 1,  1, 0, 3, 1, 1, 0, 64'h12,  2, 1};
        vecs[6]  = '{0, 0, 0, 64'h0,   0, 1,  1, 0, 3, 2, 1, 1, 64'h13,  1, 1};
        vecs[7]  = '{0, 0, 0, 64'h0,   0, 1,  1, 0, 3, 3, 0, 0, 64'h0,   0, 0};
        vecs[8]  = '{0, 0, 1, 64'h21,  1, 0,  1, 1, 3, 3, 0, 0, 64'h0,   0, 0};
        vecs[9]  = '{0, 0, 1, 64'h31,  1, 1,  1, 1, 4, 3, 1, 1, 64'h21,  1, 1};
        vecs[10] = '{0, 0, 0, 64'h0,   0, 0,  1, 0, 5, 4, 1, 1, 64'h31,  1, 1};
        vecs[11] = '{0, 0, 0, 64'h0,   0, 1,  1, 0, 5, 4, 1, 1, 64'h31,  1, 1};
        vecs[12] = '{0, 0, 0, 64'h0,   0, 0,  1, 0, 5, 5, 0, 0, 64'h0,   0, 0};
        vecs[13] = '{0, 0, 1, 64'h41,  0, 0,  1, 1, 5, 5, 0, 0, 64'h0,   0, 0};
        vecs[14] = '{0, 0, 1, 64'h42,  1, 0,  1, 1, 6, 5, 0, 0, 64'h0,   1, 0};
        vecs[15] = '{0, 0, 1, 64'h51,  0, 0,  1, 1, 7, 5, 1, 0, 64'h41,  2, 1};
        vecs[16] = '{0, 0, 1, 64'h52,  0, 0,  1, 1, 0, 5, 1, 0, 64'h41,  3, 1};
        vecs[17] = '{0, 0, 1, 64'h53,  1, 0,  1, 1, 1, 5, 1, 0, 64'h41,  4, 1};
        vecs[18] = '{0, 1, 1, 64'h99,  1, 1,  0, 0, 2, 5, 0, 0, 64'h0,   5, 2};
        vecs[19] = '{0, 0, 0, 64'h0,   0, 0,  1, 0, 0, 0, 0, 0, 64'h0,   0, 0};
        vecs[20] = '{0, 0, 1, 64'h61,  0, 1,  1, 1, 0, 0, 0, 0, 64'h0,   0, 0};
        vecs[21] = '{0, 0, 1, 64'h62,  1, 1,  1, 1, 1, 0, 0, 0, 64'h0,   1, 0};
        vecs[22] = '{1, 0, 1, 64'h63,  0, 1,  1, 1, 2, 0, 1, 0, 64'h61,  2, 1};
        vecs[23] = '{0, 0, 0, 64'h0,   0, 1,  1, 0, 0, 0, 0, 0, 64'h0,   0, 0};
        vecs[24] = '{0, 0, 1, 64'h71,  0, 1,  1, 1, 0, 0, 0, 0, 64'h0,   0, 0};
        vecs[25] = '{0, 0, 1, 64'h72,  1, 1,  1, 1, 1, 0, 0, 0, 64'h0,   1, 0};
        vecs[26] = '{0, 0, 0, 64'h0,   0, 1,  1, 0, 2, 0, 1, 0, 64'h71,  2, 1};
        vecs[27] = '{0, 0, 0, 64'h0,   0, 1,  1, 0, 2, 1, 1, 1, 64'h72,  1, 1};
        vecs[28] = '{0, 0, 0, 64'h0,   0, 0,  1, 0, 2, 2, 0, 0, 64'h0,   0, 0};
        for (int i = 0; i < 8; i++) mem[i] = '0;
        rst = 1'b1; flush_i = 1'b0; s_valid_i = 1'b0; s_data_i = '0; s_last_i = 1'b0; m_ready_i = 1'b0;
        repeat (2) @(posedge clk);
        for (int i = 0; i < 29; i++) begin
            drive(1'(vecs[i].rst), 1'(vecs[i].flush), 1'(vecs[i].sv), vecs[i].sd,
                  1'(vecs[i].sl), 1'(vecs[i].mr));
            check($sformatf("v%0d.s_ready", i), 64'(s_ready_o), 64'(vecs[i].sr));
            check($sformatf("v%0d.wren", i), 64'(buf_wren_o), 64'(vecs[i].wr));
            check($sformatf("v%0d.waddr", i), 64'(buf_waddr_o), 64'(vecs[i].wa));
            check($sformatf("v%0d.raddr", i), 64'(buf_raddr_o), 64'(vecs[i].ra));
            check($sformatf("v%0d.m_valid", i), 64'(m_valid_o), 64'(vecs[i].mv));
            check($sformatf("v%0d.m_last", i), 64'(m_last_o), 64'(vecs[i].ml));
            check($sformatf("v%0d.occ", i), 64'(occupancy_o), 64'(vecs[i].occ));
            check($sformatf("v%0d.pkt", i), 64'(pkt_cnt_o), 64'(vecs[i].pkt));
            if (vecs[i].mv != 0) check($sformatf("v%0d.m_data", i), m_data_o, vecs[i].md);
            if (vecs[i].wr != 0) check($sformatf("v%0d.wdata", i), buf_wdata_o, vecs[i].sd);
        end
        // Back-to-back single-word packets; pointers advance 20 and wrap twice
        for (int k = 0; k < 20; k++) begin
            drive(1'b0, 1'b0, 1'b1, 64'h200 + 64'(k), 1'b1, 1'b1);
            check($sformatf("stream%0d.occ", k), 64'(occupancy_o), (k == 0) ? 64'd0 : 64'd1);
            check($sformatf("stream%0d.m_valid", k), 64'(m_valid_o), (k == 0) ? 64'd0 : 64'd1);
            if (k > 0) begin
                check($sformatf("stream%0d.m_data", k), m_data_o, 64'h200 + 64'(k - 1));
                check($sformatf("stream%0d.m_last", k), 64'(m_last_o), 64'd1);
            end
        end
        drive(1'b0, 1'b0, 1'b0, 64'h0, 1'b0, 1'b1);
        check("stream_drain.m_data", m_data_o, 64'h213);
        check("stream_drain.m_valid", 64'(m_valid_o), 64'd1);
        drive(1'b0, 1'b0, 1'b0, 64'h0, 1'b0, 1'b0);
        check("stream_end.occ", 64'(occupancy_o), 64'd0);
        // Oversize 10-word packet: fills the buffer, then cuts through
        for (int k = 0; k < 8; k++) drive(1'b0, 1'b0, 1'b1, 64'h100 + 64'(k), 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b1, 64'h108, 1'b0, 1'b0);
        check("big.s_ready", 64'(s_ready_o), 64'd0);
        check("big.occ", 64'(occupancy_o), 64'd8);
        check("big.m_valid", 64'(m_valid_o), 64'd1);
        check("big.m_data", m_data_o, 64'h100);
        check("big.m_last", 64'(m_last_o), 64'd0);
        sent = 8; recv = 0;
        for (int c = 0; c < 60 && recv < 10; c++) begin
            drive(1'b0, 1'b0, 1'(sent < 10), 64'h100 + 64'(sent), 1'(sent == 9), 1'b1);
            if (m_valid_o) begin
                check($sformatf("big.pop%0d.data", recv), m_data_o, 64'h100 + 64'(recv));
                check($sformatf("big.pop%0d.last", recv), 64'(m_last_o), 64'(recv == 9));
                recv++;
            end
            if (s_valid_i && s_ready_o) sent++;
        end
        check("big.words_out", 64'(recv), 64'd10);
        drive(1'b0, 1'b0, 1'b0, 64'h0, 1'b0, 1'b0);
        check("big.end_occ", 64'(occupancy_o), 64'd0);
        check("big.end_pkt", 64'(pkt_cnt_o), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
